// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the board-output PIO arbiter.
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Bits needed to hold HOLD_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first asserted request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = IW'((32'(ptr_i) + i) % N);
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
        found    = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/pio_out_arbiter.sv
// Shares the board output PIO among NUM_REQ requesters: one Avalon write per grant,
// followed by a fixed dwell before the next update.
module pio_out_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        avm_chipselect,
  output logic                        avm_write_n,
  output logic [1:0]                  avm_address,
  output logic [DATA_W-1:0]           avm_writedata,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  last_owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(HOLD_CYCLES);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [DATA_W-1:0]    sel_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Outputs are registered, so the WRITE-cycle values (strobe, grant, owner,
  // pointer advance) are all loaded on the IDLE->WRITE transition.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (arb_any) begin
          state_d = WRITE;
          grant_d = arb_gnt;
          cs_d    = 1'b1;
          wn_d    = 1'b0;
          wdata_d = sel_data;
          last_d  = arb_idx;
          busy_d  = 1'b1;
          ptr_d   = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + IDX_W'(1);
        end
      end
      WRITE: begin
        state_d = HOLD;
        cnt_d   = CNT_W'(HOLD_CYCLES-1);
        busy_d  = 1'b1;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign grant          = grant_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_address    = PIO_DATA_ADDR;
  assign avm_writedata  = wdata_q;
  assign busy           = busy_q;
  assign last_owner     = last_q;

endmodule

// File: tb/tb_pio_out_arbiter.sv
// Directed and random checks of pio_out_arbiter against a cycle-timeline reference model.
module tb_pio_out_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     grant;
  logic             cs, wn;
  logic [1:0]       addr;
  logic [W-1:0]     wdata;
  logic             busy;
  logic [1:0]       last;

  always #5 clk = ~clk;

  pio_out_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .HOLD_CYCLES (H)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .req            (req),
    .req_data       (req_data),
    .grant          (grant),
    .avm_chipselect (cs),
    .avm_write_n    (wn),
    .avm_address    (addr),
    .avm_writedata  (wdata),
    .busy           (busy),
    .last_owner     (last)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: time remaining until the port is free, plus expected outputs.
  int           m_left;
  int           m_ptr;
  logic [N-1:0] e_grant;
  bit           e_cs;
  bit           e_busy;
  logic [W-1:0] e_data;
  int           e_last;

  int cyc;
  int last_strobe;
  int pend[N];
  int win_q[$];
  int data_q[$];
  int scyc_q[$];

  logic [N-1:0]   r;
  logic [N*W-1:0] d;
  bit             raised;
  int             n1;

  task automatic model_reset();
    m_left = 0; m_ptr = 0;
    e_grant = '0; e_cs = 0; e_busy = 0; e_data = '0; e_last = 0;
    last_strobe = -1;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] rv, input logic [N*W-1:0] dv);
    int win;
    win = -1;
    if (m_left == 0) begin
      e_grant = '0; e_cs = 0; e_busy = 0;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && rv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) begin
        e_grant      = '0;
        e_grant[win] = 1'b1;
        e_cs         = 1;
        e_busy       = 1;
        e_data       = dv[win*W +: W];
        e_last       = win;
        m_ptr        = (win + 1) % N;
        m_left       = H + 1;
      end
    end else begin
      m_left--;
      e_grant = '0; e_cs = 0;
      e_busy  = (m_left > 0);
    end
  endtask

  task automatic apply(input logic [N-1:0] rv, input logic [N*W-1:0] dv);
    req = rv; req_data = dv;
    model_step(rv, dv);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_eq("grant", grant, e_grant);
    check_eq("chipselect", cs, e_cs);
    check_eq("write_n", wn, !e_cs);
    check_eq("address", addr, 0);
    check_eq("writedata", wdata, e_data);
    check_eq("last_owner", last, e_last);
    check_eq("busy", busy, e_busy);
    check_eq("grant_onehot", $countones(grant) <= 1, 1);
    if (cs === 1'b1 && wn === 1'b0) begin
      if (last_strobe >= 0) check_eq("spacing_min", (cyc - last_strobe) >= H + 2, 1);
      last_strobe = cyc;
      scyc_q.push_back(cyc);
      data_q.push_back(int'(wdata));
    end
    if (grant != '0) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          win_q.push_back(i);
          pend[i] = 0;
        end else if (req[i]) begin
          pend[i]++;
          check_eq("starvation", pend[i] <= N - 1, 1);
        end
      end
    end
    for (int i = 0; i < N; i++) if (!req[i]) pend[i] = 0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_chipselect", cs, 0);
    check_eq("rst_write_n", wn, 1);
    check_eq("rst_address", addr, 0);
    check_eq("rst_writedata", wdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_last_owner", last, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_idle(input int n);
    repeat (n) begin
      tick();
      apply('0, d);
    end
  endtask

  task automatic clear_logs();
    win_q.delete(); data_q.delete(); scyc_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    rst = 1'b1; req = '0; req_data = '0; r = '0; d = '0;
    model_reset();
    #3 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    apply('0, d);
    run_idle(2);

    // Single request from requester 2.
    d = '0; d[2*W +: W] = 8'hA5;
    tick(); apply(4'b0100, d);
    tick();
    check_eq("t1_grant", grant, 4'b0100);
    check_eq("t1_strobe", {cs, wn}, 2'b10);
    check_eq("t1_address", addr, 0);
    check_eq("t1_data", wdata, 8'hA5);
    check_eq("t1_last", last, 2);
    apply('0, d);
    run_idle(H + 2);

    // All four from reset, each dropped after its grant.
    tick(); do_reset();
    clear_logs();
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    r = 4'hF;
    apply(r, d);
    for (int k = 0; k < 4 * (H + 2) + 6; k++) begin
      tick();
      r &= ~grant;
      apply(r, d);
    end
    check_eq("t2_count", data_q.size(), 4);
    for (int i = 0; i < data_q.size() && i < 4; i++) check_eq("t2_order", data_q[i], 32'h10 + i);
    for (int i = 1; i < scyc_q.size(); i++) check_eq("t2_spacing", scyc_q[i] - scyc_q[i-1], H + 2);

    // Requester 0 held continuously, requester 3 arrives during HOLD.
    tick(); do_reset();
    clear_logs();
    r = 4'b0001; raised = 0;
    apply(r, d);
    for (int k = 0; k < 45; k++) begin
      tick();
      if (grant[3]) r[3] = 1'b0;
      if (!raised && win_q.size() == 1 && busy) begin
        r[3] = 1'b1;
        raised = 1;
      end
      apply(r, d);
    end
    check_eq("t3_wins", win_q.size() >= 2, 1);
    if (win_q.size() >= 2) begin
      check_eq("t3_first", win_q[0], 0);
      check_eq("t3_second", win_q[1], 3);
    end
    r = '0;
    tick(); apply(r, d);
    run_idle(H + 2);

    // Requester 1 withdraws during HOLD: never granted.
    clear_logs();
    tick(); apply(4'b0001, d);
    tick(); apply('0, d);
    repeat (3) begin tick(); apply(4'b0010, d); end
    run_idle(H + 4);
    n1 = 0;
    foreach (win_q[i]) if (win_q[i] == 1) n1++;
    check_eq("t4_no_grant1", n1, 0);
    check_eq("t4_writes", win_q.size(), 1);

    // Reset mid-HOLD; pointer restarts at 0.
    tick(); apply(4'b0010, d);
    tick(); apply('0, d);
    repeat (4) begin tick(); apply('0, d); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1001, d);
    tick();
    check_eq("t5_ptr_restart", grant, 4'b0001);
    apply('0, d);
    run_idle(H + 2);
    tick(); apply(4'b1000, d);
    tick();
    check_eq("t5_req3_grant", grant, 4'b1000);
    check_eq("t5_req3_last", last, 3);
    apply('0, d);
    run_idle(H + 2);

    // Random traffic obeying the requester protocol.
    r = '0;
    for (int k = 0; k < 10000; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          if ($urandom_range(3) != 0) r[i] = 1'b0;
          else d[i*W +: W] = W'($urandom);
        end else if (r[i]) begin
          if ($urandom_range(39) == 0) r[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          r[i] = 1'b1;
          d[i*W +: W] = W'($urandom);
        end
      end
      apply(r, d);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_out_arbiter.md
# pio_out_arbiter

Round-robin arbiter and write sequencer that shares the 8-bit board output PIO among several on-chip requesters. Each requester presents a byte and a request; the block selects one, issues a single Avalon-MM write to the PIO data register (address 0), acknowledges the winner, then enforces a minimum dwell time before the next update. It sits between the control FSMs and the PIO slave's s1 port, replacing direct CPU-only ownership of the board outputs.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, PIO data width
- HOLD_CYCLES, 16, minimum cycles the port value is held after a write (>=1)

Ports:
- clk  in  1  single system clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level, held until granted
- req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
- grant  out  NUM_REQ  one-hot, one-cycle acknowledge to the winner
- avm_chipselect  out  1  PIO chipselect
- avm_write_n  out  1  PIO write strobe, active low
- avm_address  out  2  PIO register address, always 0
- avm_writedata  out  DATA_W  byte written to PIO
- busy  out  1  high in WRITE and HOLD
- last_owner  out  clog2(NUM_REQ)  index of the most recent winner

## Operation
- Reset values: avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, grant 0, busy 0, last_owner 0, priority pointer 0, state IDLE, hold counter 0.
- FSM states: IDLE, WRITE, HOLD.
- IDLE: if any req bit set, pick winner w = first set bit scanning from pointer upward, wrapping modulo NUM_REQ; register req_data slice w into avm_writedata; go to WRITE. Else stay.
- WRITE (exactly 1 cycle): avm_chipselect 1, avm_write_n 0, grant[w] 1, busy 1; last_owner <= w; pointer <= (w+1) mod NUM_REQ; counter <= HOLD_CYCLES-1; go to HOLD.
- HOLD: chipselect 0, write_n 1, busy 1; decrement counter; at counter 0 go to IDLE. req ignored in HOLD.
- avm_writedata holds its last value outside WRITE (no glitching of bus data).
- Requester must drop req the cycle after seeing grant; a req still high then counts as a new request and is served after the others by round-robin.
- Request withdrawn before grant: no write for that requester, no error.
- Requests arriving during WRITE/HOLD wait; none are lost as long as held.

## Timing
- req sampled in IDLE at cycle t -> WRITE cycle (strobe + grant) at t+1.
- HOLD occupies cycles t+2 .. t+1+HOLD_CYCLES; IDLE at t+2+HOLD_CYCLES; earliest next strobe t+3+HOLD_CYCLES.
- Back-to-back write spacing therefore exactly HOLD_CYCLES+2 cycles under continuous load.
- All outputs registered; no combinational path req -> avm_* or grant.
- Reset asserted any state: outputs go to reset values immediately (async); a WRITE in progress is dropped, no grant issued; pointer returns to 0.

## Structure
- Package pio_arb_pkg: state enum (IDLE, WRITE, HOLD), PIO_DATA_ADDR = 2'd0, counter width function.
- Sub-module rr_arbiter: combinational round-robin priority select (inputs req, pointer; outputs one-hot winner, index, any). Top holds FSM, counter, output registers.

## Test plan
- Single req[2]=1, data 0xA5 from IDLE -> one cycle later chipselect 1, write_n 0, address 0, writedata 0xA5, grant 4'b0100; last_owner 2.
- All four req high from reset, data 0x10/0x11/0x12/0x13, each dropped after grant -> writes 0x10,0x11,0x12,0x13 in order, strobes spaced 18 cycles (HOLD_CYCLES=16).
- req[0] held continuously, req[3] raised later -> after current write, 3 wins next; 0 never wins twice while 3 pending.
- req[1] raised then dropped before IDLE (during HOLD) -> no write with its data, no grant[1].
- reset pulsed mid-HOLD -> all outputs at reset values same cycle; after release req[3] alone wins, pointer restart at 0 verified with req 0 and 3 simultaneous -> 0 wins.
- Random req/data 10k cycles -> scoreboard: every strobe equals granted requester's data, grant one-hot, spacing >= HOLD_CYCLES+2, no starvation beyond NUM_REQ-1 other grants.
